// File: rtl/pwm_multichannel_generator_if.sv
// rtl/pwm_multichannel_generator_if.sv - control/status bundle for the multichannel PWM generator
interface pwm_multichannel_generator_if #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                ena;
    logic                xu;
    logic                xd;
    logic [SEL_W-1:0]    sel;
    logic [2:0]          conf;
    logic                mode;
    logic [CHANNELS-1:0] pwm;
    logic                period_start;
    logic [DUTY_W:0]     duty_rd;

    modport master (
        output ena, xu, xd, sel, conf, mode,
        input  pwm, period_start, duty_rd
    );

    modport slave (
        input  ena, xu, xd, sel, conf, mode,
        output pwm, period_start, duty_rd
    );
endinterface

// File: rtl/pwm_multichannel_generator.sv
// rtl/pwm_multichannel_generator.sv - CHANNELS-wide PWM with shared prescaler/counter
// Optional macro PWM_PHASE_STAGGER_EN staggers edge-aligned channel phases.
module pwm_multichannel_generator #(
    parameter int CHANNELS  = 4,
    parameter int DUTY_W    = 8,
    parameter int STEP      = 16,
    parameter int INIT_DUTY = 128
) (
    input logic                      clk,
    input logic                      rst_n,
    pwm_multichannel_generator_if.slave bus
);
    localparam logic [DUTY_W-1:0] CNT_MAX   = '1;
    localparam logic [DUTY_W-1:0] CNT_ONE   = DUTY_W'(1);
    localparam logic [DUTY_W:0]   INIT_D    = (DUTY_W+1)'(INIT_DUTY);
    localparam logic [DUTY_W:0]   STEP_D    = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W+1:0] STEP_X    = (DUTY_W+2)'(STEP);
    localparam logic [DUTY_W+1:0] FULL_X    = (DUTY_W+2)'(1) << DUTY_W;
    localparam logic [DUTY_W:0]   FULL_D    = (DUTY_W+1)'(1) << DUTY_W;
    localparam logic [6:0]        PRESC_ONE = 7'd1;

    logic [1:0]          r_xu_sync, r_xd_sync;
    logic                r_xu_prev, r_xd_prev;
    logic [6:0]          r_presc;
    logic [DUTY_W-1:0]   r_cnt;
    logic                r_dir_down;
    logic [2:0]          r_conf;
    logic                r_mode;
    logic [DUTY_W:0]     r_pending [CHANNELS];
    logic [DUTY_W:0]     r_active  [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    logic                w_xu_edge, w_xd_edge, w_sel_ok, w_edit;
    logic [DUTY_W:0]     w_sel_pending, w_duty_up, w_duty_dn;
    logic [DUTY_W+1:0]   w_sum;
    logic [6:0]          w_presc_top;
    logic                w_tick, w_boundary, w_dir_next;
    logic [DUTY_W-1:0]   w_cnt_next;
    logic [CHANNELS-1:0] w_pwm_next;

    assign w_xu_edge = r_xu_sync[1] & ~r_xu_prev;
    assign w_xd_edge = r_xd_sync[1] & ~r_xd_prev;
    assign w_sel_ok  = int'(bus.sel) < CHANNELS;
    // Simultaneous up and down edges cancel out.
    assign w_edit    = (w_xu_edge ^ w_xd_edge) && w_sel_ok;

    assign w_sel_pending = w_sel_ok ? r_pending[bus.sel] : '0;
    assign w_sum         = {1'b0, w_sel_pending} + STEP_X;
    assign w_duty_up     = (w_sum > FULL_X) ? FULL_D : w_sum[DUTY_W:0];
    assign w_duty_dn     = (w_sel_pending < STEP_D) ? '0 : w_sel_pending - STEP_D;

    assign w_presc_top = 7'((8'd1 << r_conf) - 8'd1);
    assign w_tick      = bus.ena && (r_presc == w_presc_top);

    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (!r_mode) begin
                w_cnt_next = r_cnt + CNT_ONE;
                w_dir_next = 1'b0;
                w_boundary = (r_cnt == CNT_MAX);
            end else if (!r_dir_down) begin
                w_cnt_next = r_cnt + CNT_ONE;
                w_dir_next = (w_cnt_next == CNT_MAX);
            end else begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (w_cnt_next == '0) begin
                    w_dir_next = 1'b0;
                    w_boundary = 1'b1;
                end
            end
            // A mode switch restarts the new period from zero, counting up.
            if (w_boundary && (bus.mode != r_mode)) begin
                w_cnt_next = '0;
                w_dir_next = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DUTY_W:0]   w_duty_next;
        logic [DUTY_W-1:0] w_phase;
        assign w_duty_next = w_boundary ? r_pending[g] : r_active[g];
`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [DUTY_W-1:0] OFFSET = DUTY_W'(g * ((1 << DUTY_W) / CHANNELS));
        logic w_mode_next;
        assign w_mode_next = w_boundary ? bus.mode : r_mode;
        assign w_phase     = w_mode_next ? w_cnt_next : w_cnt_next + OFFSET;
`else
        assign w_phase = w_cnt_next;
`endif
        assign w_pwm_next[g] = bus.ena && ({1'b0, w_phase} < w_duty_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xu_sync <= '0;
            r_xd_sync <= '0;
            r_xu_prev <= 1'b0;
            r_xd_prev <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) r_pending[i] <= INIT_D;
        end else begin
            r_xu_sync <= {r_xu_sync[0], bus.xu};
            r_xd_sync <= {r_xd_sync[0], bus.xd};
            r_xu_prev <= r_xu_sync[1];
            r_xd_prev <= r_xd_sync[1];
            if (w_edit) r_pending[bus.sel] <= w_xu_edge ? w_duty_up : w_duty_dn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_dir_down     <= 1'b0;
            r_conf         <= '0;
            r_mode         <= 1'b0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) r_active[i] <= INIT_D;
        end else begin
            if (bus.ena) r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
            r_cnt          <= w_cnt_next;
            r_dir_down     <= w_dir_next;
            r_pwm          <= w_pwm_next;
            r_period_start <= w_boundary;
            if (w_boundary) begin
                r_conf <= bus.conf;
                r_mode <= bus.mode;
                for (int i = 0; i < CHANNELS; i++) r_active[i] <= r_pending[i];
            end
        end
    end

    assign bus.pwm          = r_pwm;
    assign bus.period_start = r_period_start;
    assign bus.duty_rd      = w_sel_ok ? r_active[bus.sel] : '0;
endmodule
